// File: rtl/tdm_pkg.sv
// Shared definitions for the 2:1 TDM receive path: FSM encoding and slot width.
package tdm_pkg;

  // Default number of bits per channel slot; a frame is two slots, A first.
  localparam int TDM_W_DEFAULT = 8;

  // Receive FSM encoding; the values are fixed so that busy decodes as != IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT_A = 2'd1,
    SLOT_B = 2'd2
  } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux2_if.sv
// Bundle of the serial link input and the two channel outputs of the demux.
interface tdm_demux2_if #(
  parameter int W = tdm_pkg::TDM_W_DEFAULT
);

  logic         din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] a_data;
  logic         a_valid;
  logic [W-1:0] b_data;
  logic         b_valid;
  logic         frame_err;
  logic         busy;

  // Link side: drives the serial stream, observes the decoded channels.
  modport master (
    output din, din_valid, sync,
    input  a_data, a_valid, b_data, b_valid, frame_err, busy
  );

  // Demux side: consumes the serial stream, produces the decoded channels.
  modport slave (
    input  din, din_valid, sync,
    output a_data, a_valid, b_data, b_valid, frame_err, busy
  );

endinterface : tdm_demux2_if

// File: rtl/tdm_demux2_bit_deser.sv
// LSB-first shift-in register: writes one bit at a given index, can clear the
// partial word, and flags the beat that completes a slot.
module bit_deser
  import tdm_pkg::*;
#(
  parameter int W  = TDM_W_DEFAULT,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,    // drop the partial word before this beat's load
  input  logic          load_i,   // store bit_i at idx_i
  input  logic [CW-1:0] idx_i,
  input  logic          bit_i,
  output logic [W-1:0]  word_o,   // assembled word including this beat's bit
  output logic          done_o    // this beat fills the last bit position
);

  logic [W-1:0] shift_q;
  logic [W-1:0] shift_d;
  logic [W-1:0] base;

  // Assemble the word seen this beat and the value to retain for the next one.
  always_comb begin
    base   = {W{1'b0}};
    word_o = {W{1'b0}};
    done_o = 1'b0;
    if (clr_i) begin
      base = {W{1'b0}};
    end else begin
      base = shift_q;
    end
    word_o = base;
    if (load_i) begin
      word_o[idx_i] = bit_i;
      done_o        = (idx_i == CW'(W - 1));
    end else begin
      done_o = 1'b0;
    end
    // A completed word is handed to the consumer; start the next slot clean.
    if (done_o) begin
      shift_d = {W{1'b0}};
    end else begin
      shift_d = word_o;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= {W{1'b0}};
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule : bit_deser

// File: rtl/tdm_demux2.sv
// Receive end of the 2:1 TDM serial link: splits each sync-framed 2*W-bit
// frame into channel A and channel B words with one-cycle valid strobes.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int W  = TDM_W_DEFAULT,
  localparam int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux2_if.slave  bus
);

  tdm_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_data_q;
  logic [W-1:0]  b_data_q;
  logic          a_valid_q;
  logic          b_valid_q;
  logic          frame_err_q;

  logic          ds_load;
  logic          ds_clr;
  logic [CW-1:0] ds_idx;
  logic [W-1:0]  ds_word;
  logic          ds_done;

  // Steer the deserialiser: a sync beat always restarts at bit 0, a plain
  // beat inside a slot stores at the current counter, anything else holds.
  always_comb begin
    ds_load = 1'b0;
    ds_clr  = 1'b0;
    ds_idx  = cnt_q;
    if (bus.din_valid) begin
      if (bus.sync) begin
        ds_load = 1'b1;
        ds_clr  = 1'b1;
        ds_idx  = {CW{1'b0}};
      end else if (state_q != IDLE) begin
        ds_load = 1'b1;
      end else begin
        ds_load = 1'b0;
      end
    end else begin
      ds_load = 1'b0;
    end
  end

  bit_deser #(.W(W)) u_deser (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (ds_clr),
    .load_i (ds_load),
    .idx_i  (ds_idx),
    .bit_i  (bus.din),
    .word_o (ds_word),
    .done_o (ds_done)
  );

  // Frame FSM with slot counter, output word registers and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      a_data_q    <= {W{1'b0}};
      b_data_q    <= {W{1'b0}};
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.din_valid) begin
        case (state_q)
          IDLE: begin
            if (bus.sync) begin
              cnt_q   <= CW'(1);
              state_q <= SLOT_A;
            end else begin
              state_q <= IDLE;
            end
          end
          SLOT_A, SLOT_B: begin
            if (bus.sync) begin
              // Resync wins over completion, even on a slot's last bit.
              frame_err_q <= 1'b1;
              cnt_q       <= CW'(1);
              state_q     <= SLOT_A;
            end else if (ds_done) begin
              cnt_q <= {CW{1'b0}};
              if (state_q == SLOT_A) begin
                a_data_q  <= ds_word;
                a_valid_q <= 1'b1;
                state_q   <= SLOT_B;
              end else begin
                b_data_q  <= ds_word;
                b_valid_q <= 1'b1;
                state_q   <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_q   <= {CW{1'b0}};
            state_q <= IDLE;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bus.a_data    = a_data_q;
  assign bus.b_data    = b_data_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.b_valid   = b_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule : tdm_demux2

// File: tb/tb_tdm_demux2.sv
// Directed self-checking bench for tdm_demux2 with W = 8.
module tb_tdm_demux2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   a_cnt;
  int   b_cnt;
  int   e_cnt;

  tdm_demux2_if #(.W(8)) bus ();

  tdm_demux2 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every strobe pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.a_valid)   a_cnt++;
    if (bus.b_valid)   b_cnt++;
    if (bus.frame_err) e_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one set of inputs for one clock edge; returns just after that edge.
  task automatic step(input logic d, input logic s, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.sync      = s;
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Send a full frame; optional stall cycles (with sync=1, din_valid=0) after every beat.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input bit stall, input bit exp_err);
    int a0, b0, e0;
    a0 = a_cnt; b0 = b_cnt; e0 = e_cnt;
    for (int i = 0; i < 8; i++) begin
      step(a[i], (i == 0), 1'b1);
      if (i == 0) check("frame_err_first", {31'd0, bus.frame_err}, {31'd0, exp_err});
      if (i == 7) begin
        check("a_valid_strobe", {31'd0, bus.a_valid}, 32'd1);
        check("a_data", {24'd0, bus.a_data}, {24'd0, a});
      end
      if (stall) begin
        step(1'($urandom_range(1)), 1'b1, 1'b0);
        if (i == 7) check("a_valid_one_cycle", {31'd0, bus.a_valid}, 32'd0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(b[i], 1'b0, 1'b1);
      if (i == 7) begin
        check("b_valid_strobe", {31'd0, bus.b_valid}, 32'd1);
        check("b_data", {24'd0, bus.b_data}, {24'd0, b});
        check("a_data_hold", {24'd0, bus.a_data}, {24'd0, a});
      end
      if (stall) begin
        step(1'($urandom_range(1)), 1'b1, 1'b0);
        if (i == 7) check("b_valid_one_cycle", {31'd0, bus.b_valid}, 32'd0);
      end
    end
    check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    #1;
    check("a_strobe_count", a_cnt - a0, 32'd1);
    check("b_strobe_count", b_cnt - b0, 32'd1);
    check("err_count", e_cnt - e0, {31'd0, exp_err});
  endtask

  // Hard stop if the run ever overruns its fixed length.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, b0, e0;
    n_checks = 0; n_fail = 0;
    a_cnt = 0; b_cnt = 0; e_cnt = 0;
    rst_n = 1'b0;
    bus.din = 1'b0; bus.sync = 1'b0; bus.din_valid = 1'b0;

    // Reset with random activity on the link.
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    check("rst_a_data", {24'd0, bus.a_data}, 32'd0);
    check("rst_b_data", {24'd0, bus.b_data}, 32'd0);
    check("rst_strobes", {29'd0, bus.a_valid, bus.b_valid, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_strobe_count", a_cnt + b_cnt + e_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // Clean frame, then the same frame with stalls.
    send_frame(8'hA5, 8'h3C, 1'b0, 1'b0);
    send_frame(8'hA5, 8'h3C, 1'b1, 1'b0);

    // Ignore rules: beats without sync in IDLE, sync without din_valid.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("idle_nosync_busy", {31'd0, bus.busy}, 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("sync_novalid_busy", {31'd0, bus.busy}, 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("sync_novalid_still_idle", {31'd0, bus.busy}, 32'd0);

    // Resync at A bit 4: partial word is dropped, new frame decodes.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("partial_busy", {31'd0, bus.busy}, 32'd1);
    send_frame(8'h12, 8'hEF, 1'b0, 1'b1);
    check("resync_a_data_old_before", {24'd0, bus.a_data}, 32'h12);

    // Resync exactly on A bit 7: sync beats completion.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    send_frame(8'h96, 8'h69, 1'b0, 1'b1);

    // Async reset while receiving B bit 3.
    a0 = a_cnt; b0 = b_cnt; e0 = e_cnt;
    for (int i = 0; i < 8; i++) step(i[0], (i == 0), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_a_data", {24'd0, bus.a_data}, 32'd0);
    check("async_b_data", {24'd0, bus.b_data}, 32'd0);
    check("async_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("async_a_count", a_cnt - a0, 32'd1);
    check("async_b_count", b_cnt - b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("post_async_idle", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h5A, 8'hC3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux2

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receiving end of the team's 2:1 time-multiplexed serial link; the link's transmitter selects channel A or B onto one wire, and this block undoes that selection.
- Deserialises a framed bit stream into two W-bit channel words (A, then B) and presents each word with a one-cycle valid strobe.
- Sits between the serial link input and the channel consumers.
- Detects frame-sync violations.

Parameters:
- W, 8, bits per channel slot; one frame is 2*W bits, A slot first.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit; LSB first within each slot.
- din_valid  input  1  din and sync are sampled only when 1; when 0 the block stalls.
- sync  input  1  marks the first bit (A bit 0) of a frame; qualified by din_valid.
- a_data  output  W  last complete channel-A word.
- a_valid  output  1  one-cycle strobe: a_data updated.
- b_data  output  W  last complete channel-B word.
- b_valid  output  1  one-cycle strobe: b_data updated.
- frame_err  output  1  one-cycle strobe: sync arrived mid-frame.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - a_data = 0, b_data = 0.
  - a_valid, b_valid, frame_err = 0.
  - state = IDLE, bit counter = 0, shift register = 0.
- States: IDLE, SLOT_A, SLOT_B. A "beat" is a rising edge with din_valid = 1. On non-beat edges, state, counter and shift register hold, and all strobes are 0.
- IDLE:
  - Beat with sync = 1: capture din as bit 0, counter = 1, go to SLOT_A.
  - Beat with sync = 0: ignore it and stay in IDLE.
- SLOT_A, beat with sync = 0:
  - Store din at bit position counter.
  - If counter = W-1: in the same edge, a_data takes the assembled word, a_valid = 1 for the next cycle, counter = 0, go to SLOT_B.
  - Otherwise counter increments.
- SLOT_B, beat with sync = 0: same as SLOT_A, but updates b_data and b_valid, then returns to IDLE. Every frame needs its own sync.
- Sync in SLOT_A or SLOT_B (beat with sync = 1):
  - frame_err = 1 for one cycle.
  - Discard the partial word; no valid strobe for it.
  - Treat this beat as A bit 0 of a new frame: counter = 1, state = SLOT_A.
  - This applies even on the last bit of a slot: resync wins over completion.
- Strobe latency: a_valid/b_valid are registered and go high in the cycle right after the edge that sampled the slot's last bit.
- Output hold: a_data and b_data keep their value until the next completed word.
- busy is combinational from state.
- Counter width is clog2(W). The counter never exceeds W-1 and wraps to 0 at the end of each slot.
- Reset asserted mid-frame: everything clears immediately; no strobe for the partial frame. After rst_n is released the block waits in IDLE for sync.

Decomposition:
- Shared package tdm_pkg holds:
  - state encoding constants IDLE = 2'd0, SLOT_A = 2'd1, SLOT_B = 2'd2;
  - the default slot width.
- One natural sub-module, bit_deser: W-bit LSB-first shift-in register with load-at-index, clear, and a done flag.
- The FSM, strobes and output registers stay in tdm_demux2.

Test Plan:
- Reset: hold rst_n = 0 with random din/sync -> all outputs 0, busy = 0. Release -> still idle.
- Clean frame, W = 8, din_valid constant 1: sync on first beat, A = 8'hA5, B = 8'h3C (LSB first) -> a_valid pulses the cycle after beat 8 with a_data = 8'hA5; b_valid pulses 8 cycles later with b_data = 8'h3C; busy = 0 afterwards.
- Stall: same frame with din_valid alternating 1/0 -> identical words; each strobe follows the last valid beat of its slot by one cycle; no extra strobes.
- Resync: sync reasserted at A bit 4 -> frame_err single pulse, no a_valid. The following 16 beats carry A = 8'h12, B = 8'hEF -> both received correctly.
- Ignore rules:
  - Beats without sync in IDLE -> no state change.
  - sync = 1 with din_valid = 0 -> no frame start.
- Async reset at B bit 3 -> outputs clear without waiting for clk, no b_valid. A new frame after release decodes correctly.
